// File: rtl/cla_16.sv
// cla_16: registered 16-bit two-level carry-lookahead adder.
// Four 4-bit lookahead groups feed a second-level unit that produces
// the group carry-ins and the carry out. All carries are flat
// sum-of-products, so no carry ripples through the groups. S, Cout, PG
// and GG are registered, which gives one cycle of latency and accepts a
// new operation every cycle.
module cla_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout,
    output logic        PG,
    output logic        GG
);

    logic [15:0] p;          // bit propagate
    logic [15:0] g;          // bit generate
    logic [3:0]  grp_p;      // group propagate, one per 4-bit group
    logic [3:0]  grp_g;      // group generate, one per 4-bit group
    logic [4:0]  grp_c;      // carry into each group; grp_c[4] is c16
    logic [15:0] c;          // carry into each bit position

    logic [15:0] s_d,    s_q;
    logic        cout_d, cout_q;
    logic        pg_d,   pg_q;
    logic        gg_d,   gg_q;

    // Bit-level propagate and generate terms.
    always_comb begin
        p = A ^ B;
        g = A & B;
    end

    // First level: group propagate and generate for each 4-bit slice.
    always_comb begin
        grp_p = '0;
        grp_g = '0;
        for (int k = 0; k < 4; k++) begin
            grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    // Second level: every group carry-in comes straight from Cin and the group P/G.
    always_comb begin
        grp_c    = '0;
        grp_c[0] = Cin;
        grp_c[1] = grp_g[0]
                 | (grp_p[0] & Cin);
        grp_c[2] = grp_g[1]
                 | (grp_p[1] & grp_g[0])
                 | (grp_p[1] & grp_p[0] & Cin);
        grp_c[3] = grp_g[2]
                 | (grp_p[2] & grp_g[1])
                 | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & Cin);
        grp_c[4] = grp_g[3]
                 | (grp_p[3] & grp_g[2])
                 | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & Cin);
    end

    // Inside each group: bit carries expanded from the group carry-in (no ripple).
    always_comb begin
        c = '0;
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = grp_c[k];
            c[4*k+1] = g[4*k]
                     | (p[4*k] & grp_c[k]);
            c[4*k+2] = g[4*k+1]
                     | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & grp_c[k]);
            c[4*k+3] = g[4*k+2]
                     | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
        end
    end

    // Pre-register results: sum bits, carry out and Cin-independent group P/G.
    always_comb begin
        s_d    = p ^ c;
        cout_d = grp_c[4];
        pg_d   = grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0];
        gg_d   = grp_g[3]
               | (grp_p[3] & grp_g[2])
               | (grp_p[3] & grp_p[2] & grp_g[1])
               | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
    end

    // Output registers; reset clears them at once, dropping any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            pg_q   <= 1'b0;
            gg_q   <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
            pg_q   <= pg_d;
            gg_q   <= gg_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign PG   = pg_q;
    assign GG   = gg_q;

endmodule

// File: tb/tb_cla_16.sv
// tb_cla_16: scoreboard bench for cla_16. The driver applies a vector on
// the falling edge and queues its expected result; the monitor pops one
// entry shortly after each rising edge and compares it with the outputs.
module tb_cla_16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        cout;
        logic        pg;
        logic        gg;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic [15:0] S;
    logic        Cout;
    logic        PG;
    logic        GG;

    int checks;
    int errors;
    exp_t exp_q[$];

    cla_16 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (S),
        .Cout (Cout),
        .PG   (PG),
        .GG   (GG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply a vector now and queue the result expected after the next rising edge.
    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [15:0] s, input logic cout, input logic pg, input logic gg);
        exp_t e;
        A = a;
        B = b;
        Cin = cin;
        e.a = a; e.b = b; e.cin = cin;
        e.s = s; e.cout = cout; e.pg = pg; e.gg = gg;
        exp_q.push_back(e);
    endtask

    // Independent behavioural model: 17-bit sum, PG as AND of propagates, GG as carry with Cin=0.
    task automatic drive_model(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] full;
        logic [16:0] nocin;
        logic        pg;
        full  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        nocin = {1'b0, a} + {1'b0, b};
        pg    = &(a ^ b);
        drive(a, b, cin, full[15:0], full[16], pg, nocin[16]);
    endtask

    // Monitor: one comparison per queued result, taken just after the rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (S !== e.s || Cout !== e.cout || PG !== e.pg || GG !== e.gg) begin
                errors++;
                $display("FAIL sum A=%h B=%h Cin=%b got S=%h Cout=%b PG=%b GG=%b want S=%h Cout=%b PG=%b GG=%b",
                         e.a, e.b, e.cin, S, Cout, PG, GG, e.s, e.cout, e.pg, e.gg);
            end
            checks++;
            if (Cout !== (GG | (PG & e.cin))) begin
                errors++;
                $display("FAIL cout_identity A=%h B=%h Cin=%b got Cout=%b want GG|(PG&Cin)=%b",
                         e.a, e.b, e.cin, Cout, GG | (PG & e.cin));
            end
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if (S !== 16'h0000 || Cout !== 1'b0 || PG !== 1'b0 || GG !== 1'b0) begin
            errors++;
            $display("FAIL %s got S=%h Cout=%b PG=%b GG=%b want all zero", name, S, Cout, PG, GG);
        end
    endtask

    // Stimulus: reset, directed vectors, mid-stream reset, random vectors, drain.
    initial begin
        int waited;
        checks = 0;
        errors = 0;
        A = 16'h0; B = 16'h0; Cin = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_zero("reset_initial");
        A = 16'hFFFF; B = 16'hFFFF; Cin = 1'b1;
        @(posedge clk); #1;
        check_zero("reset_held_over_edge");

        @(negedge clk);
        rst_n = 1'b1;
        // Directed vectors, back to back, hand-computed results.
        drive(16'h0005, 16'h000A, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(16'd50,   16'd25,   1'b1, 16'h004C, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(16'hFFFB, 16'h000A, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b1);
        @(negedge clk); drive(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        @(negedge clk); drive(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        @(negedge clk); drive(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        @(negedge clk); drive(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        @(negedge clk); drive(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        @(negedge clk); drive(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        @(negedge clk); drive(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
        @(negedge clk); drive(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Mid-stream reset: outputs nonzero, then reset between edges.
        @(negedge clk); drive(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1 check_zero("reset_async_midstream");
        A = 16'h5555; B = 16'h5555; Cin = 1'b1;
        @(posedge clk); #1;
        check_zero("reset_midstream_held");
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

        // Random vectors against the behavioural model.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            drive_model(16'($urandom), 16'($urandom), 1'($urandom));
        end

        // Drain with a bounded wait.
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
